// File: rtl/branch_sequencer.sv
// Branch sequencer: accepts one branch at a time, resolves it and redirects fetch.
// Define BRANCH_RAS_EN to build the return-address stack used by CALL/RET.
module branch_sequencer #(
    parameter int PC_W      = 16,
    parameter int DATA_W    = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [4:0]        opcode,
    input  logic [3:0]        func_code,
    input  logic [PC_W-1:0]   br_pc,
    input  logic [PC_W-1:0]   br_target,
    input  logic              reg_valid,
    input  logic [DATA_W-1:0] reg_data,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    input  logic              redirect_ack,
    output logic              flush,
    output logic              resolved_nt,
    output logic              illegal,
    output logic              ras_ovf,
    output logic              ras_unf
);
    typedef enum logic [1:0] {IDLE, WAIT_REG, REDIRECT} state_t;

    localparam logic [4:0] OP_JUMP = 5'b00011;
    localparam logic [4:0] OP_COND = 5'b00100;

    state_t          state_q, state_d;
    logic [PC_W-1:0] target_q, target_d;
    logic [1:0]      cond_q, cond_d;
    logic            illegal_q, illegal_d;
    logic            nt_q, nt_d;
    logic            handshake, is_jmp, is_call, is_ret, is_cond, taken;
    logic            push, pop;
    logic            ras_hit;
    logic [PC_W-1:0] ras_top;

    assign handshake = br_valid && br_ready;
    assign is_jmp    = (opcode == OP_JUMP) && (func_code == 4'd0);
    assign is_call   = (opcode == OP_JUMP) && (func_code == 4'd1);
    assign is_ret    = (opcode == OP_JUMP) && (func_code == 4'd2);
    assign is_cond   = (opcode == OP_COND) && (func_code <= 4'd2);
    assign push      = handshake && is_call;
    assign pop       = handshake && is_ret;

    // cond_q holds func_code[1:0]: 0 BEQZ, 1 BLTZ, 2 BGTZ (operand is signed)
    always_comb begin
        case (cond_q)
            2'd0:    taken = (reg_data == '0);
            2'd1:    taken = reg_data[DATA_W-1];
            default: taken = !reg_data[DATA_W-1] && (reg_data != '0);
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        target_d  = target_q;
        cond_d    = cond_q;
        illegal_d = 1'b0;
        nt_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    cond_d   = func_code[1:0];
                    target_d = br_target;
                    if (is_jmp || is_call) begin
                        state_d = REDIRECT;
                    end else if (is_ret) begin
                        state_d = REDIRECT;
                        if (ras_hit) target_d = ras_top;
                    end else if (is_cond) begin
                        state_d = WAIT_REG;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            WAIT_REG: begin
                if (reg_valid) begin
                    if (taken) begin
                        state_d = REDIRECT;
                    end else begin
                        state_d = IDLE;
                        nt_d    = 1'b1;
                    end
                end
            end
            REDIRECT: if (redirect_ack) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            target_q  <= '0;
            cond_q    <= '0;
            illegal_q <= 1'b0;
            nt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            cond_q    <= cond_d;
            illegal_q <= illegal_d;
            nt_q      <= nt_d;
        end
    end

    assign br_ready       = (state_q == IDLE);
    assign redirect_valid = (state_q == REDIRECT);
    assign redirect_pc    = redirect_valid ? target_q : '0;
    assign flush          = redirect_valid && redirect_ack;
    assign illegal        = illegal_q;
    assign resolved_nt    = nt_q;

`ifdef BRANCH_RAS_EN
    localparam int              PTR_W     = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(RAS_DEPTH);

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, unf_q;

    // ptr_q is the next free slot; a full push wraps onto the oldest entry
    assign ras_hit = (cnt_q != '0);
    assign ras_top = ras_mem[ptr_q - PTR_W'(1)];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (cnt_q != DEPTH_CNT) cnt_d = cnt_q + (PTR_W+1)'(1);
        end else if (pop && ras_hit) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= push && (cnt_q == DEPTH_CNT);
            unf_q <= pop && !ras_hit;
        end
    end

    // NOTE: stack storage is not reset; the occupancy count gates every read.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ptr_q] <= br_pc + PC_W'(1);
    end

    assign ras_ovf = ovf_q;
    assign ras_unf = unf_q;
`else
    logic unused_ras;

    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
    assign ras_ovf    = 1'b0;
    assign ras_unf    = 1'b0;
    assign unused_ras = ^{br_pc, push, pop};
`endif
endmodule
